apb_to_wb_bridge: RTL

APB completer that forwards each APB transfer as one Wishbone classic single-read or single-write cycle on a Wishbone master port. It lets APB-side initiators, such as a debug or config master, reach the SoC Wishbone fabric. It is the counterpart of the Wishbone-slave-to-APB path: Wishbone master on one side, APB slave on the other. A timeout converts a hung Wishbone cycle into an APB error.

---
 rtl/apb_wb_pkg.sv | 15 +
 rtl/wb_timeout_counter.sv | 39 +++
 rtl/apb_to_wb_bridge.sv | 138 +++++++++++++
 3 files changed

// File: rtl/apb_wb_pkg.sv
// Shared types and constants for the APB-to-Wishbone bridge.
// The state encoding is 2 bits wide.
package apb_wb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWbReq = 2'd1,
        StResp  = 2'd2
    } state_e;

    localparam logic [3:0] SEL_ALL = 4'hF;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts cycles spent waiting on a Wishbone response.
// 'expired' flags the last permitted cycle of the wait.
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Saturate at TIMEOUT so the count never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == CntLast);

endmodule

// File: rtl/apb_to_wb_bridge.sv
// APB completer that issues one Wishbone classic cycle per APB transfer.
// A hung Wishbone cycle is aborted after TIMEOUT cycles and reported as pslverr.
module apb_to_wb_bridge
    import apb_wb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [3:0]        pstrb,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [ADDR_W-1:0] wb_adr,
    output logic [DATA_W-1:0] wb_dat_w,
    input  logic [DATA_W-1:0] wb_dat_r,
    output logic              wb_we,
    output logic [3:0]        wb_sel,
    output logic              wb_cyc,
    output logic              wb_stb,
    input  logic              wb_ack,
    input  logic              wb_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_w_q, dat_w_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              pslverr_q, pslverr_d;
    logic              setup;
    logic              expired;

    assign setup = psel && !penable;

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q != StWbReq),
        .en      (state_q == StWbReq),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            adr_q     <= '0;
            dat_w_q   <= '0;
            prdata_q  <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_w_q   <= dat_w_d;
            prdata_q  <= prdata_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (setup) state_d = StWbReq;
            StWbReq: if (wb_err || wb_ack || expired) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Response priority while waiting: err over ack over timeout.
    always_comb begin
        adr_d     = adr_q;
        dat_w_d   = dat_w_q;
        prdata_d  = prdata_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        pslverr_d = pslverr_q;
        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    adr_d   = paddr;
                    dat_w_d = pwdata;
                    we_d    = pwrite;
                    sel_d   = pwrite ? pstrb : SEL_ALL;
                    cyc_d   = 1'b1;
                end
            end
            StWbReq: begin
                if (wb_err) begin
                    cyc_d     = 1'b0;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                end else if (wb_ack) begin
                    cyc_d     = 1'b0;
                    pslverr_d = 1'b0;
                    if (!we_q) prdata_d = wb_dat_r;
                end else if (expired) begin
                    cyc_d     = 1'b0;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                end
            end
            StResp:  pslverr_d = 1'b0;
            default: cyc_d = 1'b0;
        endcase
    end

    always_comb begin
        pready   = (state_q == StResp);
        pslverr  = pslverr_q;
        prdata   = prdata_q;
        wb_adr   = adr_q;
        wb_dat_w = dat_w_q;
        wb_we    = we_q;
        wb_sel   = sel_q;
        wb_cyc   = cyc_q;
        wb_stb   = cyc_q;
    end

endmodule
